// File: rtl/heartbeat_kicker.sv
// Watchdog feeder: issues one incrementing kick per window while the supervised
// logic shows liveness, starves the watchdog after repeated silence, flags unexpected bites.
module heartbeat_kicker #(
  parameter int PERIOD     = 5,
  parameter int MISS_LIMIT = 3,
  parameter int WIDTH      = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             task_alive,
  input  logic             wd_expired,
  output logic [WIDTH-1:0] kick_out,
  output logic             kick_strobe,
  output logic             starved,
  output logic             fault,
  output logic [1:0]       state
);

  localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
  localparam int MW = (MISS_LIMIT > 0) ? $clog2(MISS_LIMIT + 1) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(PERIOD - 1);
  localparam logic [MW-1:0] MISS_LAST = MW'(MISS_LIMIT - 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_STARVED = 2'd2,
    S_FAULT   = 2'd3
  } state_t;

  state_t           state_r, state_s;
  logic [CW-1:0]    cnt_r, cnt_s;
  logic [MW-1:0]    miss_r, miss_s;
  logic             alive_r, alive_s;
  logic [WIDTH-1:0] kick_r, kick_s;
  logic             strobe_r, strobe_s;
  logic             starved_r, starved_s;
  logic             fault_r, fault_s;

  logic win_end_s;
  logic alive_now_s;

  assign win_end_s   = (cnt_r == CNT_LAST);
  assign alive_now_s = alive_r | task_alive;

  // State and datapath registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r   <= S_IDLE;
      cnt_r     <= '0;
      miss_r    <= '0;
      alive_r   <= 1'b0;
      kick_r    <= '0;
      strobe_r  <= 1'b0;
      starved_r <= 1'b0;
      fault_r   <= 1'b0;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      miss_r    <= miss_s;
      alive_r   <= alive_s;
      kick_r    <= kick_s;
      strobe_r  <= strobe_s;
      starved_r <= starved_s;
      fault_r   <= fault_s;
    end
  end

  // Next-state selection; an unexpected bite outranks everything in RUN
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (ena) state_s = S_RUN;
        else     state_s = S_IDLE;
      end
      S_RUN: begin
        if (wd_expired)                                      state_s = S_FAULT;
        else if (!ena)                                       state_s = S_IDLE;
        else if (win_end_s && !alive_now_s && miss_r == MISS_LAST) state_s = S_STARVED;
        else                                                 state_s = S_RUN;
      end
      S_STARVED: begin
        if (!ena) state_s = S_IDLE;
        else      state_s = S_STARVED;
      end
      S_FAULT: state_s = S_FAULT;
      default: state_s = S_IDLE;
    endcase
  end

  // Next values of counters and registered outputs
  always_comb begin
    cnt_s     = cnt_r;
    miss_s    = miss_r;
    alive_s   = alive_r;
    kick_s    = kick_r;
    strobe_s  = 1'b0;
    starved_s = starved_r;
    fault_s   = fault_r;
    case (state_r)
      S_IDLE: begin
        cnt_s     = '0;
        miss_s    = '0;
        alive_s   = 1'b0;
        starved_s = 1'b0;
        if (ena) begin
          kick_s   = kick_r + WIDTH'(1);
          strobe_s = 1'b1;
        end else begin
          kick_s   = kick_r;
        end
      end
      S_RUN: begin
        if (wd_expired) begin
          fault_s = 1'b1;
        end else if (!ena) begin
          cnt_s   = '0;
          miss_s  = '0;
          alive_s = 1'b0;
        end else if (win_end_s) begin
          cnt_s   = '0;
          alive_s = 1'b0;
          if (alive_now_s) begin
            kick_s   = kick_r + WIDTH'(1);
            strobe_s = 1'b1;
            miss_s   = '0;
          end else if (miss_r == MISS_LAST) begin
            miss_s    = miss_r;
            starved_s = 1'b1;
          end else begin
            miss_s = miss_r + MW'(1);
          end
        end else begin
          cnt_s   = cnt_r + CW'(1);
          alive_s = alive_now_s;
        end
      end
      S_STARVED: begin
        if (!ena) begin
          cnt_s     = '0;
          miss_s    = '0;
          alive_s   = 1'b0;
          starved_s = 1'b0;
        end else begin
          starved_s = 1'b1;
        end
      end
      S_FAULT: fault_s = 1'b1;
      default: begin
        cnt_s   = '0;
        miss_s  = '0;
        alive_s = 1'b0;
      end
    endcase
  end

  assign kick_out    = kick_r;
  assign kick_strobe = strobe_r;
  assign starved     = starved_r;
  assign fault       = fault_r;
  assign state       = state_r;

endmodule

// File: tb/tb_heartbeat_kicker.sv
// Directed bench for heartbeat_kicker: cycle model compared every cycle plus
// hand-computed literal expectations at key points.
module tb_heartbeat_kicker;

  localparam int P  = 5;
  localparam int ML = 3;

  logic       clk = 1'b0;
  logic       rst_n, ena, task_alive, wd_expired;
  logic [7:0] kick_out;
  logic       kick_strobe, starved, fault;
  logic [1:0] state;

  int checks = 0;
  int errors = 0;

  heartbeat_kicker #(.PERIOD(P), .MISS_LIMIT(ML), .WIDTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .task_alive(task_alive),
    .wd_expired(wd_expired), .kick_out(kick_out), .kick_strobe(kick_strobe),
    .starved(starved), .fault(fault), .state(state)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: mode 0 idle, 1 running, 2 starved, 3 faulted
  int m_mode = 0, m_kick = 0, m_age = 0, m_misses = 0;
  bit m_strobe = 0, m_starved = 0, m_fault = 0, m_heard = 0, model_valid = 0;

  always @(posedge clk) begin
    m_strobe = 0;
    if (rst_n !== 1'b1) begin
      m_mode = 0; m_kick = 0; m_age = 0; m_misses = 0;
      m_starved = 0; m_fault = 0; m_heard = 0; model_valid = 1;
    end else begin
      case (m_mode)
        0: if (ena) begin
          m_kick = (m_kick + 1) % 256; m_strobe = 1; m_mode = 1;
          m_age = 0; m_misses = 0; m_heard = 0;
        end
        1: begin
          if (wd_expired) begin
            m_mode = 3; m_fault = 1;
          end else if (!ena) begin
            m_mode = 0;
          end else begin
            m_heard = m_heard || task_alive;
            if (m_age % P == P - 1) begin
              if (m_heard) begin
                m_kick = (m_kick + 1) % 256; m_strobe = 1; m_misses = 0;
              end else begin
                m_misses++;
                if (m_misses == ML) begin m_mode = 2; m_starved = 1; end
              end
              m_heard = 0;
            end
            m_age++;
          end
        end
        2: if (!ena) begin m_mode = 0; m_starved = 0; end
        default: ;
      endcase
    end
    #2;
    if (model_valid) begin
      check("model_kick_out", int'(kick_out), m_kick);
      check("model_kick_strobe", int'(kick_strobe), int'(m_strobe));
      check("model_starved", int'(starved), int'(m_starved));
      check("model_fault", int'(fault), int'(m_fault));
      check("model_state", int'(state), m_mode);
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n = 1'b0; tick(2); rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0; ena = 1'b0; task_alive = 1'b0; wd_expired = 1'b0;
    // 1: reset and idle
    tick(2);
    check("rst_kick_out", int'(kick_out), 0);
    check("rst_strobe", int'(kick_strobe), 0);
    check("rst_starved", int'(starved), 0);
    check("rst_fault", int'(fault), 0);
    check("rst_state", int'(state), 0);
    rst_n = 1'b1;
    tick(3); wd_expired = 1'b1; tick(1); wd_expired = 1'b0; tick(6);
    check("idle_kick_out", int'(kick_out), 0);
    check("idle_fault", int'(fault), 0);

    // 2: alive pulse mid-window
    ena = 1'b1; tick(1);
    check("entry_kick", int'(kick_out), 1);
    check("entry_strobe", int'(kick_strobe), 1);
    check("entry_state", int'(state), 1);
    for (int w = 0; w < 2; w++) begin
      tick(2); task_alive = 1'b1; tick(1); task_alive = 1'b0; tick(1);
      check("mid_window_strobe", int'(kick_strobe), 0);
      tick(1);
      check("window_kick", int'(kick_out), 2 + w);
      check("window_strobe", int'(kick_strobe), 1);
    end
    ena = 1'b0; tick(1);
    check("disable_state", int'(state), 0);

    // 3: starvation
    do_reset(); ena = 1'b1; tick(1);
    check("starve_entry", int'(kick_out), 1);
    tick(14);
    check("pre_starved", int'(starved), 0);
    tick(1);
    check("starved_flag", int'(starved), 1);
    check("starved_state", int'(state), 2);
    check("starved_kick", int'(kick_out), 1);
    wd_expired = 1'b1; tick(1); wd_expired = 1'b0; tick(1);
    check("bite_no_fault", int'(fault), 0);
    check("bite_state", int'(state), 2);
    ena = 1'b0; tick(1);
    check("unstarve_state", int'(state), 0);
    check("unstarve_flag", int'(starved), 0);
    ena = 1'b1; tick(1);
    check("reentry_kick", int'(kick_out), 2);
    ena = 1'b0; tick(1);

    // 4: unexpected bite at window end
    do_reset(); ena = 1'b1; task_alive = 1'b1; tick(1);
    tick(4); wd_expired = 1'b1; tick(1); wd_expired = 1'b0;
    check("fault_no_kick", int'(kick_out), 1);
    check("fault_strobe", int'(kick_strobe), 0);
    check("fault_flag", int'(fault), 1);
    check("fault_state", int'(state), 3);
    for (int i = 0; i < 20; i++) begin
      ena = 1'($urandom_range(1)); task_alive = 1'($urandom_range(1)); tick(1);
    end
    check("fault_sticky", int'(state), 3);
    check("fault_kick_frozen", int'(kick_out), 1);
    rst_n = 1'b0; ena = 1'b0; task_alive = 1'b0; tick(1);
    check("fault_cleared", int'(fault), 0);
    check("fault_clr_state", int'(state), 0);
    rst_n = 1'b1;

    // 5: wrap, alive only in last cycle of window
    do_reset(); ena = 1'b1; tick(1);
    for (int w = 0; w < 254; w++) begin
      tick(4); task_alive = 1'b1; tick(1); task_alive = 1'b0;
    end
    check("kick_ff", int'(kick_out), 255);
    tick(4); task_alive = 1'b1; tick(1); task_alive = 1'b0;
    check("kick_wrap", int'(kick_out), 0);
    check("wrap_strobe", int'(kick_strobe), 1);

    // 6: disable at window end, reset mid-window, re-enable
    task_alive = 1'b1; tick(4); ena = 1'b0; tick(1);
    check("dis_win_state", int'(state), 0);
    check("dis_win_strobe", int'(kick_strobe), 0);
    check("dis_win_kick", int'(kick_out), 0);
    ena = 1'b1; tick(1);
    check("reen_kick", int'(kick_out), 1);
    tick(2); rst_n = 1'b0; tick(1);
    check("midrst_kick", int'(kick_out), 0);
    check("midrst_state", int'(state), 0);
    rst_n = 1'b1; tick(1);
    check("post_rst_kick", int'(kick_out), 1);
    check("post_rst_strobe", int'(kick_strobe), 1);
    ena = 1'b0; task_alive = 1'b0; tick(3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
